sprite_compositor: RTL

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

---
 rtl/sprite_compositor.sv | 111 +++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: N_SPR-channel sprite overlay with priority mux, background fill and per-frame collision flags.
// Ports: VGA_CLK/reset clock and async active-high reset; ativo/perdeu display enable and game-over blanking;
// VGA_X/VGA_Y raw beam counters; spr_x/spr_y/spr_shift/spr_en per-sprite placement, scale and visibility;
// ld_en/ld_spr/ld_addr/ld_rgb bitmap write port; VGA_R/G/B pixel colour two cycles after VGA_X/VGA_Y;
// colisao per-frame collision flags against sprite 0; frame_tick one-cycle pulse at the frame boundary.
module sprite_compositor #(
  parameter int N_SPR = 4,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int H_OFF = 144,
  parameter int V_OFF = 35,
  parameter int BG_LEVEL = 30,
  localparam int AW = $clog2(SPR_W * SPR_H)
) (
  input  logic                 VGA_CLK,
  input  logic                 reset,
  input  logic                 ativo,
  input  logic                 perdeu,
  input  logic [9:0]           VGA_X,
  input  logic [9:0]           VGA_Y,
  input  logic [10*N_SPR-1:0]  spr_x,
  input  logic [10*N_SPR-1:0]  spr_y,
  input  logic [2*N_SPR-1:0]   spr_shift,
  input  logic [N_SPR-1:0]     spr_en,
  input  logic                 ld_en,
  input  logic [2:0]           ld_spr,
  input  logic [AW-1:0]        ld_addr,
  input  logic [2:0]           ld_rgb,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B,
  output logic [N_SPR-1:0]     colisao,
  output logic                 frame_tick
);
  localparam int CW = $clog2(SPR_W);
  logic [10:0] sx, sy;
  logic a1, p1, fb1, blank, any;
  logic [N_SPR-1:0] hit, col, acc;
  logic [2:0] rgb1 [N_SPR];
  logic [2:0] sel;
  // bit 10 is the sign of the 11-bit screen coordinate
  assign sx = {1'b0, VGA_X} - 11'(H_OFF);
  assign sy = {1'b0, VGA_Y} - 11'(V_OFF);
  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    logic [11:0] x, y, w, h, dx, dy;
    logic [1:0] sh;
    logic cov, c;
    logic [AW-1:0] addr;
    logic [2:0] mem [SPR_W*SPR_H];
    logic [2:0] q;
    assign x = {2'b0, spr_x[10*i +: 10]};
    assign y = {2'b0, spr_y[10*i +: 10]};
    assign sh = spr_shift[2*i +: 2];
    assign w = 12'(SPR_W) << sh;
    assign h = 12'(SPR_H) << sh;
    assign dx = {1'b0, sx} - x;
    assign dy = {1'b0, sy} - y;
    // right/bottom bounds are 12-bit so a sprite near 1023 never wraps back to column/row 0
    assign cov = spr_en[i] && !sx[10] && !sy[10] && {1'b0, sx} >= x && {1'b0, sx} < x + w
                 && {1'b0, sy} >= y && {1'b0, sy} < y + h;
    assign addr = AW'(((dy >> sh) << CW) + (dx >> sh));
    always_ff @(posedge VGA_CLK)
      if (ld_en && ld_spr == 3'(i)) mem[ld_addr] <= ld_rgb;
    always_ff @(posedge VGA_CLK or posedge reset)
      if (reset) begin
        q <= 3'b000;
        c <= 1'b0;
      end else begin
        q <= mem[addr];
        c <= cov;
      end
    assign rgb1[i] = q;
    assign hit[i] = c && q != 3'b000;
  end
  // walk from the highest index down so the lowest-index opaque sprite wins
  always_comb begin
    sel = 3'b000;
    for (int k = N_SPR - 1; k >= 0; k--)
      if (hit[k]) sel = rgb1[k];
  end
  assign any = |hit;
  assign blank = !a1 || p1;
  assign col = hit & {N_SPR{hit[0]}} & ~N_SPR'(1);
  always_ff @(posedge VGA_CLK or posedge reset)
    if (reset) begin
      a1 <= 1'b0;
      p1 <= 1'b0;
      fb1 <= 1'b0;
    end else begin
      a1 <= ativo;
      p1 <= perdeu;
      fb1 <= VGA_X == 10'd0 && VGA_Y == 10'd0;
    end
  // on the boundary pixel the old acc is published and that pixel's own collisions seed the new acc
  always_ff @(posedge VGA_CLK or posedge reset)
    if (reset) begin
      VGA_R <= 8'd0;
      VGA_G <= 8'd0;
      VGA_B <= 8'd0;
      colisao <= '0;
      acc <= '0;
      frame_tick <= 1'b0;
    end else begin
      VGA_R <= blank ? 8'd0 : any ? {8{sel[2]}} : 8'(BG_LEVEL);
      VGA_G <= blank ? 8'd0 : any ? {8{sel[1]}} : 8'(BG_LEVEL);
      VGA_B <= blank ? 8'd0 : any ? {8{sel[0]}} : 8'(BG_LEVEL);
      frame_tick <= fb1;
      acc <= fb1 ? col : acc | col;
      if (fb1) colisao <= acc;
    end
endmodule
